dmem_arbiter: RTL and testbench

//  Shares the single-ported data memory (one read addr, one write port, 1-cycle registered read)

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter_rr_arbiter2.sv | 18 +
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RSP
    } state_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bundle for both arbiter ports.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS-1:0]       req_ready;
    logic [NUM_PORTS-1:0]       req_we;
    logic [NUM_PORTS-1:0][31:0] req_addr;
    logic [NUM_PORTS-1:0][31:0] req_wdata;
    logic [NUM_PORTS-1:0]       rsp_valid;
    logic [NUM_PORTS-1:0]       rsp_ready;
    logic [31:0]                rsp_rdata;
    logic                       rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port that was not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two requesters.
// Optional address checking is enabled by defining DMEM_ARB_CHK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_SIZE  = 1024,
    parameter int ADDR_SIZE = 7
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic [31:0]   mem_read_addr,
    input  logic [31:0]   mem_read_data,
    output logic [31:0]   mem_write_addr,
    output logic [31:0]   mem_write_data,
    output logic          mem_write_enable
);

`ifdef DMEM_ARB_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_SIZE);

    generate
        if (ADDR_SIZE < 2 || MEM_SIZE < 1) begin : g_bad_geometry
            $error("dmem_arbiter: ADDR_SIZE must be >= 2 and MEM_SIZE >= 1");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        last_q;
    logic        gnt_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] raddr_q;

    logic [1:0]  grant;
    logic        gsel;
    logic        accept;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        addr_bad;

    rr_arbiter2 u_rr (
        .req   (bus.req_valid),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        gsel      = grant[1];
        sel_we    = bus.req_we[gsel];
        sel_addr  = bus.req_addr[gsel];
        sel_wdata = bus.req_wdata[gsel];
        addr_bad  = CHK_EN && ((sel_addr[1:0] != 2'b00) ||
                               ({2'b00, sel_addr[31:2]} >= WORD_LIMIT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Accept is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        bus.rsp_rdata    = '0;
        bus.rsp_err      = 1'b0;
        mem_read_addr    = raddr_q;
        mem_write_addr   = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst && (bus.req_valid != '0)) begin
                    accept        = 1'b1;
                    bus.req_ready = grant;
                    if (sel_we && !addr_bad) begin
                        mem_write_enable = 1'b1;
                        mem_write_addr   = sel_addr;
                        mem_write_data   = sel_wdata;
                    end
                    if (!sel_we && !addr_bad) begin
                        mem_read_addr = sel_addr;
                        state_d       = RD_WAIT;
                    end else begin
                        state_d = RSP;
                    end
                end
            end
            RD_WAIT: state_d = RSP;
            RSP: begin
                bus.rsp_valid = port_onehot(gnt_q);
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rdata_q is cleared on every accept so writes and errors respond with 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            if (accept) begin
                last_q  <= gsel;
                gnt_q   <= gsel;
                err_q   <= addr_bad;
                rdata_q <= '0;
                if (!sel_we && !addr_bad) raddr_q <= sel_addr;
            end
            if (state_q == RD_WAIT) rdata_q <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 1024-word registered-read memory.
module tb_dmem_arbiter;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem [0:1023];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   we_pulses = 0;
    exp_t q[$];
    bit   seen = 1'b0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MEM_SIZE(1024), .ADDR_SIZE(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .mem_read_addr    (mem_read_addr),
        .mem_read_data    (mem_read_data),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_enable) mem[mem_write_addr[11:2]] <= mem_write_data;
        mem_read_data <= mem[mem_read_addr[11:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: compares against the queue head on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (bus.rsp_valid != 2'b00) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", {30'b0, bus.rsp_valid}, 32'h0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (q[0].lat >= 0) check("rsp_latency", cyc - q[0].acc, q[0].lat);
                end
                if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
                    check("rsp_port", {30'b0, bus.rsp_valid}, 32'(2'b01 << q[0].port));
                    check("rsp_rdata", bus.rsp_rdata, q[0].rdata);
                    check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, q[0].err});
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (rst && mem_write_enable) we_pulses++;

    task automatic push_exp(input int p, input logic [31:0] rd, input logic err, input int acc, input int lat);
        exp_t e;
        e.port = p; e.rdata = rd; e.err = err; e.acc = acc; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic issue(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd_e, input bit err_e, input bit push, input int lat,
                         output int acc);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b1;
        bus.req_we[p]    = we;
        bus.req_addr[p]  = addr;
        bus.req_wdata[p] = wdata;
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk);
            if (bus.req_ready[p]) begin
                acc = cyc;
                if (push) push_exp(p, rd_e, err_e, acc, lat);
            end
        end
        if (acc < 0) check("accept_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 2'b11;

        // Reset state with both requests pending
        repeat (3) @(negedge clk);
        check("rst_req_ready", {30'b0, bus.req_ready}, 0);
        check("rst_rsp_valid", {30'b0, bus.rsp_valid}, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_mem_we", {31'b0, mem_write_enable}, 0);
        check("rst_mem_raddr", mem_read_addr, 0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;

        // Test 1: write then read back; port 1 seeds another word
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1, a0);
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 2, a0);
        issue(1, 1'b1, 32'h40, 32'hA5A55A5A, 32'h0, 1'b0, 1'b1, 1, a1);
        wait_idle();

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Test 2: simultaneous reads alternate, port 0 first after reset
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 32'hDEADBEEF, 1'b0, 0, -1);
            push_exp(1, 32'hA5A55A5A, 1'b0, 0, -1);
            fork
                issue(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 0, a0);
                issue(1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 0, a1);
            join
            check("rr_port0_first", {31'b0, (a0 < a1)}, 1);
            wait_idle();
        end

        // Test 3: response stall holds outputs and blocks new accepts
        bus.rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h40, 32'h0, 32'hA5A55A5A, 1'b0, 1'b1, 2, a0);
        bus.req_valid[1] = 1'b1;
        bus.req_we[1]    = 1'b0;
        bus.req_addr[1]  = 32'h10;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("stall_rsp_valid", {30'b0, bus.rsp_valid}, 32'h1);
            check("stall_rsp_rdata", bus.rsp_rdata, 32'hA5A55A5A);
            check("stall_req_ready", {30'b0, bus.req_ready}, 0);
            check("stall_raddr_hold", mem_read_addr, 32'h40);
        end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready[0] = 1'b1;
        wait_idle();

        // Test 4: port 1 write wins (port 0 granted last) and the read sees it
        push_exp(1, 32'h0, 1'b0, 0, -1);
        push_exp(0, 32'h1234, 1'b0, 0, -1);
        fork
            issue(1, 1'b1, 32'h20, 32'h1234, 32'h0, 1'b0, 1'b0, 0, a1);
            issue(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 0, a0);
        join
        check("raw_write_first", {31'b0, (a1 < a0)}, 1);
        wait_idle();
        check("raw_mem_word", mem[8], 32'h1234);

        // Test 5: reset during RD_WAIT discards the transaction
        issue(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 0, a0);
        bus.req_valid[0] = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", {30'b0, bus.req_ready}, 0);
        check("mid_rst_rsp_valid", {30'b0, bus.rsp_valid}, 0);
        check("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
        check("mid_rst_mem_raddr", mem_read_addr, 0);
        check("mid_rst_mem_waddr", mem_write_addr | mem_write_data, 0);
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_rsp", {30'b0, bus.rsp_valid}, 0);
        issue(1, 1'b0, 32'h20, 32'h0, 32'h1234, 1'b0, 1'b1, 2, a1);
        wait_idle();

`ifdef DMEM_ARB_CHK_EN
        // Test 6: misaligned and out-of-range accesses become error responses
        a0 = we_pulses;
        issue(0, 1'b1, 32'h13, 32'hBAD0BAD0, 32'h0, 1'b1, 1'b1, 1, a1);
        issue(1, 1'b1, 32'h1000, 32'hBAD0BAD0, 32'h0, 1'b1, 1'b1, 1, a1);
        issue(0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1, 1, a1);
        wait_idle();
        check("chk_no_we_pulse", we_pulses - a0, 0);
        check("chk_mem_word4", mem[4], 32'hDEADBEEF);
        check("chk_mem_word0", mem[0], 32'h0);
`else
        // Unchecked build: low address bits pass through and are ignored by memory
        issue(0, 1'b1, 32'h13, 32'h77, 32'h0, 1'b0, 1'b1, 1, a1);
        issue(1, 1'b0, 32'h10, 32'h0, 32'h77, 1'b0, 1'b1, 2, a1);
        wait_idle();
        check("nochk_mem_word4", mem[4], 32'h77);
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
